// File: rtl/obstacle_follower_if.sv
// obstacle_follower_if -- handshake/data bundle for one obstacle-follower lane.
//   master : scroll/player side (drives move_tick, lead_pos, lane_en, player_*)
//   slave  : obstacle_follower (drives obj_x0..2, valid, frozen, hit, hit_count)
interface obstacle_follower_if;
    logic       move_tick;
    logic [9:0] lead_pos;
    logic       lane_en;
    logic [9:0] player_x;
    logic       player_in_lane;
    logic [9:0] obj_x0;
    logic [9:0] obj_x1;
    logic [9:0] obj_x2;
    logic       valid;
    logic       frozen;
    logic       hit;
    logic [7:0] hit_count;

    modport master (
        output move_tick, lead_pos, lane_en, player_x, player_in_lane,
        input  obj_x0, obj_x1, obj_x2, valid, frozen, hit, hit_count
    );

    modport slave (
        input  move_tick, lead_pos, lane_en, player_x, player_in_lane,
        output obj_x0, obj_x1, obj_x2, valid, frozen, hit, hit_count
    );
endinterface

// File: rtl/obstacle_follower.sv
// obstacle_follower -- three horizontally spaced followers trailing a scroll
// leader on a 640-pixel wrapping line, with player collision detection.
//   clk    : 25 MHz pixel clock
//   rst_n  : asynchronous active-low reset, synchronous release
//   bus    : obstacle_follower_if.slave
//            in : move_tick, lead_pos[9:0], lane_en, player_x[9:0], player_in_lane
//            out: obj_x0..2[9:0], valid, frozen, hit (1-cycle), hit_count[7:0]
// Flow: IDLE/TRACK --tick--> CHECK (one cycle, tests registered positions)
//       --> HIT on collision (frozen for HIT_TICKS ticks, then reload + CHECK)
//       --> TRACK otherwise. lane_en=0 forces IDLE from anywhere.
module obstacle_follower #(
    parameter int GAP       = 160,
    parameter int OBJ_W     = 32,
    parameter int HIT_TICKS = 25
) (
    input  logic clk,
    input  logic rst_n,
    obstacle_follower_if.slave bus
);
    localparam int NUM_OBJ = 3;

    typedef enum logic [1:0] {IDLE, TRACK, CHECK, HIT} state_t;

    state_t state_q, state_d;
    logic [NUM_OBJ-1:0][9:0] obj_q;
    logic [NUM_OBJ-1:0][9:0] load_pos;
    logic [NUM_OBJ-1:0]      coll;
    logic [7:0] hold_q, hold_d;
    logic [7:0] cnt_q;
    logic       hit_q, hit_d;
    logic       ld, any_coll;

    // Per-follower position load and wrap-aware collision distance.
    // lead_pos + 2*GAP <= 639 + 426 < 1280, so one conditional subtract wraps.
    for (genvar k = 0; k < NUM_OBJ; k++) begin : g_obj
        logic [10:0] sum;
        logic [10:0] d;
        assign sum         = {1'b0, bus.lead_pos} + 11'(k * GAP);
        assign load_pos[k] = (sum >= 11'd640) ? 10'(sum - 11'd640) : sum[9:0];
        assign d           = (bus.player_x >= obj_q[k])
                           ? ({1'b0, bus.player_x} - {1'b0, obj_q[k]})
                           : ({1'b0, bus.player_x} + 11'd640 - {1'b0, obj_q[k]});
        assign coll[k]     = (d < 11'(OBJ_W));
    end

    // Any number of overlapping followers is still a single hit.
    assign any_coll = bus.player_in_lane && (bus.player_x < 10'd640) && (|coll);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        hit_d   = 1'b0;
        ld      = 1'b0;
        if (!bus.lane_en) begin
            state_d = IDLE;
            hold_d  = 8'd0;
        end else begin
            case (state_q)
                IDLE, TRACK: begin
                    if (bus.move_tick) begin
                        ld      = 1'b1;
                        state_d = CHECK;
                    end
                end
                // move_tick is deliberately not looked at here.
                CHECK: begin
                    if (any_coll) begin
                        state_d = HIT;
                        hit_d   = 1'b1;
                        hold_d  = 8'(HIT_TICKS);
                    end else begin
                        state_d = TRACK;
                    end
                end
                HIT: begin
                    if (bus.move_tick) begin
                        if (hold_q <= 8'd1) begin
                            ld      = 1'b1;
                            hold_d  = 8'd0;
                            state_d = CHECK;
                        end else begin
                            hold_d = hold_q - 8'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            obj_q   <= '0;
            hold_q  <= 8'd0;
            hit_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            hit_q   <= hit_d;
            if (!bus.lane_en)
                obj_q <= '0;
            else if (ld)
                obj_q <= load_pos;
            if (hit_d && cnt_q != 8'hFF)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.obj_x0    = obj_q[0];
    assign bus.obj_x1    = obj_q[1];
    assign bus.obj_x2    = obj_q[2];
    assign bus.valid     = (state_q != IDLE);
    assign bus.frozen    = (state_q == HIT);
    assign bus.hit       = hit_q;
    assign bus.hit_count = cnt_q;
endmodule

// File: tb/tb_obstacle_follower.sv
// Directed bench for obstacle_follower (GAP=160, OBJ_W=32, HIT_TICKS=3).
module tb_obstacle_follower;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    obstacle_follower_if bus();

    obstacle_follower #(.GAP(160), .OBJ_W(32), .HIT_TICKS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [9:0] lp);
        bus.lead_pos  = lp;
        bus.move_tick = 1'b1;
        step();
        bus.move_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.move_tick = 1'b0; bus.lead_pos = '0; bus.lane_en = 1'b0;
        bus.player_x = '0; bus.player_in_lane = 1'b0;
        step(); step();
        total++;
        if ({bus.obj_x0, bus.obj_x1, bus.obj_x2, bus.valid, bus.frozen, bus.hit, bus.hit_count} !== 41'd0) begin
            bad++;
            $display("FAIL reset_outputs got obj=%0d/%0d/%0d v=%0b f=%0b h=%0b cnt=%0d want all 0",
                     bus.obj_x0, bus.obj_x1, bus.obj_x2, bus.valid, bus.frozen, bus.hit, bus.hit_count);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_track();
        bus.lane_en = 1'b1;
        tick(10'd100);
        total++;
        if ({bus.obj_x0, bus.obj_x1, bus.obj_x2} !== {10'd100, 10'd260, 10'd420} || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL track_load got %0d/%0d/%0d v=%0b want 100/260/420 v=1",
                     bus.obj_x0, bus.obj_x1, bus.obj_x2, bus.valid);
        end
        step();
        total++;
        if (bus.hit !== 1'b0 || bus.frozen !== 1'b0 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL track_nohit got h=%0b f=%0b v=%0b want 0/0/1", bus.hit, bus.frozen, bus.valid);
        end
        bus.lead_pos = 10'd300;
        step(); step();
        total++;
        if (bus.obj_x0 !== 10'd100) begin
            bad++;
            $display("FAIL track_hold got %0d want 100", bus.obj_x0);
        end
        // second tick lands in CHECK and must be dropped
        tick(10'd200);
        tick(10'd300);
        step();
        total++;
        if ({bus.obj_x0, bus.obj_x1, bus.obj_x2} !== {10'd200, 10'd360, 10'd520}) begin
            bad++;
            $display("FAIL check_ignores_tick got %0d/%0d/%0d want 200/360/520",
                     bus.obj_x0, bus.obj_x1, bus.obj_x2);
        end
    endtask

    task automatic test_wrap();
        tick(10'd600);
        total++;
        if ({bus.obj_x0, bus.obj_x1, bus.obj_x2} !== {10'd600, 10'd120, 10'd280}) begin
            bad++;
            $display("FAIL wrap_600 got %0d/%0d/%0d want 600/120/280", bus.obj_x0, bus.obj_x1, bus.obj_x2);
        end
        step();
        tick(10'd639);
        total++;
        if ({bus.obj_x0, bus.obj_x1, bus.obj_x2} !== {10'd639, 10'd159, 10'd319}) begin
            bad++;
            $display("FAIL wrap_639 got %0d/%0d/%0d want 639/159/319", bus.obj_x0, bus.obj_x1, bus.obj_x2);
        end
        step();
    endtask

    task automatic test_collide();
        bus.player_in_lane = 1'b1;
        bus.player_x = 10'd130;
        tick(10'd100);
        step();
        total++;
        if (bus.hit !== 1'b1 || bus.hit_count !== 8'd1 || bus.frozen !== 1'b1) begin
            bad++;
            $display("FAIL hit_d30 got h=%0b cnt=%0d f=%0b want 1/1/1", bus.hit, bus.hit_count, bus.frozen);
        end
        step();
        total++;
        if (bus.hit !== 1'b0 || bus.frozen !== 1'b1) begin
            bad++;
            $display("FAIL hit_one_cycle got h=%0b f=%0b want 0/1", bus.hit, bus.frozen);
        end
        tick(10'd400);
        tick(10'd400);
        total++;
        if ({bus.obj_x0, bus.obj_x1, bus.obj_x2} !== {10'd100, 10'd260, 10'd420} || bus.frozen !== 1'b1) begin
            bad++;
            $display("FAIL hit_frozen got %0d/%0d/%0d f=%0b want 100/260/420 f=1",
                     bus.obj_x0, bus.obj_x1, bus.obj_x2, bus.frozen);
        end
        tick(10'd50);
        total++;
        if ({bus.obj_x0, bus.obj_x1, bus.obj_x2} !== {10'd50, 10'd210, 10'd370} || bus.frozen !== 1'b0) begin
            bad++;
            $display("FAIL hit_release got %0d/%0d/%0d f=%0b want 50/210/370 f=0",
                     bus.obj_x0, bus.obj_x1, bus.obj_x2, bus.frozen);
        end
        step();
        bus.player_x = 10'd132;
        tick(10'd100);
        step();
        total++;
        if (bus.hit !== 1'b0 || bus.hit_count !== 8'd1 || bus.frozen !== 1'b0) begin
            bad++;
            $display("FAIL nohit_d32 got h=%0b cnt=%0d f=%0b want 0/1/0", bus.hit, bus.hit_count, bus.frozen);
        end
    endtask

    task automatic test_wrap_collide();
        bus.player_x = 10'd5;
        tick(10'd620);
        step();
        total++;
        if (bus.hit !== 1'b1 || bus.hit_count !== 8'd2) begin
            bad++;
            $display("FAIL wrap_hit_d25 got h=%0b cnt=%0d want 1/2", bus.hit, bus.hit_count);
        end
        // lane drop wins over a simultaneous tick in HIT
        bus.lane_en = 1'b0;
        tick(10'd50);
        total++;
        if ({bus.obj_x0, bus.obj_x1, bus.obj_x2} !== 30'd0 || bus.valid !== 1'b0 ||
            bus.frozen !== 1'b0 || bus.hit_count !== 8'd2) begin
            bad++;
            $display("FAIL lane_drop got %0d/%0d/%0d v=%0b f=%0b cnt=%0d want 0/0/0 v=0 f=0 cnt=2",
                     bus.obj_x0, bus.obj_x1, bus.obj_x2, bus.valid, bus.frozen, bus.hit_count);
        end
        bus.lane_en = 1'b1;
        bus.player_x = 10'd12;
        tick(10'd620);
        step();
        total++;
        if (bus.hit !== 1'b0 || bus.frozen !== 1'b0 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL wrap_nohit_d32 got h=%0b f=%0b v=%0b want 0/0/1", bus.hit, bus.frozen, bus.valid);
        end
        // 640-620=20 would overlap, but x>=640 never collides
        bus.player_x = 10'd640;
        tick(10'd620);
        step();
        total++;
        if (bus.hit !== 1'b0 || bus.hit_count !== 8'd2) begin
            bad++;
            $display("FAIL offscreen_player got h=%0b cnt=%0d want 0/2", bus.hit, bus.hit_count);
        end
    endtask

    task automatic test_reset_mid_hit();
        bus.player_x = 10'd130;
        for (int i = 0; i < 40 && bus.hit_count != 8'd5; i++) tick(10'd100);
        total++;
        if (bus.hit_count !== 8'd5 || bus.frozen !== 1'b1) begin
            bad++;
            $display("FAIL reach_cnt5 got cnt=%0d f=%0b want 5/1", bus.hit_count, bus.frozen);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.obj_x0, bus.obj_x1, bus.obj_x2, bus.valid, bus.frozen, bus.hit, bus.hit_count} !== 41'd0) begin
            bad++;
            $display("FAIL async_reset got obj=%0d/%0d/%0d v=%0b f=%0b h=%0b cnt=%0d want all 0",
                     bus.obj_x0, bus.obj_x1, bus.obj_x2, bus.valid, bus.frozen, bus.hit, bus.hit_count);
        end
        step();
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_saturate();
        int n = 0;
        bus.lane_en = 1'b1;
        bus.player_in_lane = 1'b1;
        bus.player_x = 10'd130;
        bus.lead_pos = 10'd100;
        bus.move_tick = 1'b1;
        for (int c = 0; c < 3000 && n < 256; c++) begin
            step();
            if (bus.hit === 1'b1) begin
                n++;
                if (n == 255) begin
                    total++;
                    if (bus.hit_count !== 8'd255) begin
                        bad++;
                        $display("FAIL cnt_at_255 got %0d want 255", bus.hit_count);
                    end
                end
            end
        end
        bus.move_tick = 1'b0;
        total++;
        if (n != 256 || bus.hit_count !== 8'd255) begin
            bad++;
            $display("FAIL cnt_saturate got hits=%0d cnt=%0d want 256/255", n, bus.hit_count);
        end
    endtask

    initial begin
        test_reset();
        test_track();
        test_wrap();
        test_collide();
        test_wrap_collide();
        test_reset_mid_hit();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
